// File: rtl/dq_pkg.sv
`default_nettype none
// ============================================================================
// Package : dq_pkg
// Desc    : Shared constants and types for the Dq (8380417) reduction datapath.
// Rev     : 1.0  initial release
// ============================================================================
package dq_pkg;

   localparam logic [22:0] DQ      = 23'd8380417;
   localparam int          PROD_W  = 48;
   localparam int          COEF_W  = 23;
   // Wide enough for the largest supported requester count (8).
   localparam int          TAG_IDW = 3;

   typedef struct packed {
      logic               v;
      logic [TAG_IDW-1:0] id;
   } redu_tag_t;

endpackage
`default_nettype wire

// File: rtl/dq_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dq_rr_arbiter
// Desc   : Round-robin one-hot grant starting at ptr, gated by a credit flag.
// Rev    : 1.0  initial release
// ============================================================================
module dq_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic            credit_ok,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic [IDW-1:0]  next_ptr
);

   always_comb begin : p_search
      int   w_idx;
      logic w_found;
      gnt      = '0;
      gnt_id   = ptr;
      next_ptr = ptr;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (credit_ok && !w_found && req[w_idx]) begin
            w_found    = 1'b1;
            gnt[w_idx] = 1'b1;
            gnt_id     = IDW'(w_idx);
            next_ptr   = (w_idx == NREQ - 1) ? '0 : IDW'(w_idx + 1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dq_redu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dq_redu_arbiter
// Desc   : Shares one pipelined Dq reduction core among NREQ requesters with a
//          credit-protected result FIFO. Define REDU_PERF_EN for perf counters.
// Rev    : 1.0  initial release
// ============================================================================
module dq_redu_arbiter
   import dq_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int IDW        = $clog2(NREQ),
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*PROD_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [PROD_W-1:0]      core_in,
   input  logic [COEF_W-1:0]      core_out,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [COEF_W-1:0]      rsp_data,
   input  logic                   rsp_ready,
   input  logic                   drain,
   output logic                   idle
`ifdef REDU_PERF_EN
   ,
   output logic [31:0]            perf_issued,
   output logic [31:0]            perf_stall
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [IDW-1:0]    r_ptr;
   logic [IDW-1:0]    w_next_ptr;
   logic [IDW-1:0]    w_gnt_id;
   logic [NREQ-1:0]   w_gnt;
   logic              w_credit_ok;
   logic              w_xfer;
   int                w_inflight;
   redu_tag_t         r_tag [LAT];

   logic [COEF_W-1:0] r_mem_data [FIFO_DEPTH];
   logic [IDW-1:0]    r_mem_id   [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic [IDW-1:0]    w_push_id;
   logic              w_load;

   always_comb begin
      w_inflight = 0;
      for (int s = 0; s < LAT; s++) w_inflight = w_inflight + int'(r_tag[s].v);
   end

   // The output register holds an entry too, so it is part of the credit budget.
   assign w_credit_ok = rst && !drain &&
                        ((int'(r_count) + int'(rsp_valid) + w_inflight) < FIFO_DEPTH);

   dq_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req       (req_valid),
      .credit_ok (w_credit_ok),
      .ptr       (r_ptr),
      .gnt       (w_gnt),
      .gnt_id    (w_gnt_id),
      .next_ptr  (w_next_ptr)
   );

   assign req_ready = w_gnt;
   assign w_xfer    = |w_gnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         core_in <= '0;
         for (int s = 0; s < LAT; s++) r_tag[s] <= '0;
      end else begin
         if (w_xfer) begin
            r_ptr   <= w_next_ptr;
            core_in <= req_data[PROD_W*int'(w_gnt_id) +: PROD_W];
         end
         r_tag[0].v  <= w_xfer;
         r_tag[0].id <= TAG_IDW'(w_gnt_id);
         for (int s = 1; s < LAT; s++) r_tag[s] <= r_tag[s-1];
      end
   end

   assign w_push    = r_tag[LAT-1].v;
   assign w_push_id = IDW'(r_tag[LAT-1].id);
   assign w_load    = (!rsp_valid || rsp_ready) && (r_count != '0);
   assign idle      = (w_inflight == 0) && (r_count == '0) && !rsp_valid;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= core_out;
         r_mem_id[r_wr_ptr]   <= w_push_id;
      end
   end

   // rsp_* are a registered head stage refilled from the FIFO array.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= r_mem_data[r_rd_ptr];
            rsp_id    <= r_mem_id[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_load);
      end
   end

`ifdef REDU_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (w_xfer) perf_issued <= perf_issued + 32'd1;
         if ((|req_valid) && !w_credit_ok) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dq_redu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dq_redu_arbiter
// Desc   : Directed scoreboard bench for dq_redu_arbiter with a behavioural core.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dq_redu_arbiter;
   import dq_pkg::*;

   localparam int NREQ       = 4;
   localparam int IDW        = 2;
   localparam int LAT        = 3;
   localparam int FIFO_DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid;
   logic [191:0]  req_data;
   logic [3:0]    req_ready;
   logic [47:0]   core_in;
   logic [22:0]   core_out;
   logic          rsp_valid;
   logic [1:0]    rsp_id;
   logic [22:0]   rsp_data;
   logic          rsp_ready;
   logic          drain;
   logic          idle;
`ifdef REDU_PERF_EN
   logic [31:0]   perf_issued;
   logic [31:0]   perf_stall;
`endif

   always #5 clk = ~clk;

   dq_redu_arbiter #(
      .NREQ       (NREQ),
      .IDW        (IDW),
      .LAT        (LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .core_in     (core_in),
      .core_out    (core_out),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_ready   (rsp_ready),
      .drain       (drain),
      .idle        (idle)
`ifdef REDU_PERF_EN
      ,
      .perf_issued (perf_issued),
      .perf_stall  (perf_stall)
`endif
   );

   // Reduction core: the registered core_in is its first stage, LAT-1 more follow.
   logic [22:0] core_pipe [LAT-1];
   always @(posedge clk) begin
      core_pipe[0] <= 23'(core_in % 48'(DQ));
      for (int s = 1; s < LAT - 1; s++) core_pipe[s] <= core_pipe[s-1];
   end
   assign core_out = core_pipe[LAT-2];

   typedef struct packed {
      logic [1:0]  id;
      logic [22:0] data;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        m_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [47:0] dat [4];
   logic [22:0] res [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input logic [22:0] d);
      exp_q.push_back('{id: 2'(id), data: d});
   endtask

   task automatic wait_empty(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic load_table();
      req_data = {dat[3], dat[2], dat[1], dat[0]};
   endtask

   // Monitor: every accepted response is checked against the scoreboard head.
   always @(negedge clk) begin
      if (rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d data %0d, expected none", rsp_id, rsp_data);
         end else begin
            m_e = exp_q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(m_e.id));
            check("rsp_data", 64'(rsp_data), 64'(m_e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int lat;
      dat[0] = 48'd0;
      dat[1] = 48'd8380417;
      dat[2] = 48'd70231372333056;
      dat[3] = 48'd16760835;
      res[0] = 23'd0;
      res[1] = 23'd0;
      res[2] = 23'd1;
      res[3] = 23'd1;
      rst       = 1'b0;
      drain     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      load_table();

      // Reset state, with requests pending
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_core_in", 64'(core_in), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;

      // All four valid: grants rotate 0,1,2,3,0,...
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         push_exp(k % 4, res[k % 4]);
         @(posedge clk);
         #1;
      end
      req_valid = 4'h0;
      wait_empty("rr_drain", 40);

      // Single request and its latency
      req_data[47:0] = 48'd8380418;
      req_valid = 4'b0001;
      @(negedge clk);
      check("single_grant", 64'(req_ready), 64'd1);
      push_exp(0, 23'd1);
      @(posedge clk);
      #1 req_valid = 4'h0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("single_latency", 64'(lat), 64'(LAT + 1));
      wait_empty("single_drain", 20);
      load_table();

      // Backpressure: exactly FIFO_DEPTH transfers, then no grants
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k < FIFO_DEPTH) begin
            check("bp_grant", 64'(req_ready), 64'(4'b0001 << ((1 + k) % 4)));
            push_exp((1 + k) % 4, res[(1 + k) % 4]);
         end else begin
            check("bp_stall", 64'(req_ready), 64'd0);
            check("bp_hold_id", 64'({rsp_valid, rsp_id}), 64'({1'b1, 2'd1}));
            check("bp_hold_data", 64'(rsp_data), 64'(res[1]));
         end
         @(posedge clk);
         #1;
      end
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      wait_empty("bp_release", 40);

      // Drain with three in flight
      req_valid = 4'hF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("drain_pre_grant", 64'(req_ready), 64'(4'b0010 << k));
         push_exp(1 + k, res[1 + k]);
         @(posedge clk);
         #1;
      end
      drain = 1'b1;
      #1;
      check("drain_ready", 64'(req_ready), 64'd0);
      check("drain_busy", 64'(idle), 64'd0);
      lat = 0;
      while (!idle && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("drain_idle", 64'(idle), 64'd1);
      check("drain_done", 64'(exp_q.size()), 64'd0);
      drain     = 1'b0;
      req_valid = 4'h0;

      // Asynchronous reset in the middle of a burst
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("mid_rst_req_ready", 64'(req_ready), 64'd0);
      check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_core_in", 64'(core_in), 64'd0);
      check("mid_rst_idle", 64'(idle), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      rst       = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_quiet", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      req_data[143:96] = 48'd41902208;
      req_valid = 4'b0100;
      @(negedge clk);
      check("post_rst_grant", 64'(req_ready), 64'(4'b0100));
      push_exp(2, 23'd123);
      @(posedge clk);
      #1 req_valid = 4'h0;
      wait_empty("post_rst_rsp", 20);
      load_table();

`ifdef REDU_PERF_EN
      // 8 credit-limited transfers + 5 stalled cycles, then 2 more transfers
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         if (k < FIFO_DEPTH) push_exp(k % 4, res[k % 4]);
         @(posedge clk);
         #1;
      end
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      wait_empty("perf_flush", 40);
      req_valid = 4'hF;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         push_exp(k, res[k]);
         @(posedge clk);
         #1;
      end
      req_valid = 4'h0;
      wait_empty("perf_tail", 20);
      check("perf_issued", 64'(perf_issued), 64'd10);
      check("perf_stall", 64'(perf_stall), 64'd5);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
